// File: rtl/cfg_load_pkg.sv
// rtl/cfg_load_pkg.sv - register offsets, sequencer states and layer-table field helpers
package cfg_load_pkg;

    localparam logic [4:0] REG_WEIGHT = 5'd0;
    localparam logic [4:0] REG_BIAS   = 5'd4;
    localparam logic [4:0] REG_OUT    = 5'd8;
    localparam logic [4:0] REG_LAYER  = 5'd12;
    localparam logic [4:0] REG_NEURON = 5'd16;
    localparam logic [4:0] REG_STATUS = 5'd24;
    localparam logic [4:0] REG_SRST   = 5'd28;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET_LAYER,
        ST_SET_NEURON,
        ST_FETCH,
        ST_LOAD,
        ST_PUSH,
        ST_FINISH
    } state_t;

    // Layer index is 0-based here; layer 1 sits in the least significant field.
    function automatic logic [7:0] neurons_of(input logic [63:0] packed_n, input logic [2:0] layer);
        return packed_n[{layer, 3'b000} +: 8];
    endfunction

    function automatic logic [15:0] weights_of(input logic [127:0] packed_w, input logic [2:0] layer);
        return packed_w[{layer, 4'b0000} +: 16];
    endfunction

endpackage

// File: rtl/cfg_load_seq_if.sv
// rtl/cfg_load_seq_if.sv - parameter-memory read port and register-write request bundle
interface cfg_load_seq_if #(
    parameter int MEM_W  = 17,
    parameter int MEM_AW = 15
) ();

    logic              mem_en;
    logic [MEM_AW-1:0] mem_addr;
    logic [MEM_W-1:0]  mem_rdata;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [4:0]        cfg_addr;
    logic [31:0]       cfg_wdata;

    modport master (
        output mem_en,
        output mem_addr,
        input  mem_rdata,
        output cfg_valid,
        input  cfg_ready,
        output cfg_addr,
        output cfg_wdata
    );

    modport slave (
        input  mem_en,
        input  mem_addr,
        output mem_rdata,
        input  cfg_valid,
        output cfg_ready,
        input  cfg_addr,
        input  cfg_wdata
    );

endinterface

// File: rtl/cfg_load_seq.sv
// rtl/cfg_load_seq.sv - walks the packed weight/bias image and replays it as register writes
module cfg_load_seq
    import cfg_load_pkg::*;
#(
    parameter int             NUM_LAYERS = 4,
    parameter logic [63:0]    NEURONS_L  = 64'h0000_0000_0A0A_1E1E,
    parameter logic [127:0]   WEIGHTS_L  = 128'h0000_0000_0000_0000_000A_001E_001E_0310,
    parameter int             MEM_W      = 17,
    parameter int             MEM_AW     = 15
) (
    input  logic           s_axi_aclk,
    input  logic           s_axi_aresetn,
    input  logic           start,
    input  logic           abort,
    output logic           busy,
    output logic           done,
    cfg_load_seq_if.master bus
);

    localparam int         PAD    = 32 - MEM_W;
    localparam logic [3:0] NUM_L4 = 4'(NUM_LAYERS);

    state_t            state_q, state_d;
    logic [2:0]        layer_q, layer_d;
    logic [7:0]        neuron_q, neuron_d;
    logic [15:0]       weight_q, weight_d;
    logic [MEM_AW-1:0] ptr_q, ptr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              abort_pend_q, abort_pend_d;

    logic              busy_c, done_c, mem_en_c, cfg_valid_c;
    logic [4:0]        cfg_addr_c;

    logic [7:0]        n_cur;
    logic [15:0]       w_cur;
    logic              is_bias, last_neuron, last_layer, abort_now;
    logic [31:0]       next_layer_id, next_neuron_id, rdata_ext;

    always_comb begin
        n_cur          = neurons_of(NEURONS_L, layer_q);
        w_cur          = weights_of(WEIGHTS_L, layer_q);
        is_bias        = (weight_q >= w_cur);
        last_neuron    = (({1'b0, neuron_q} + 9'd1) >= {1'b0, n_cur});
        last_layer     = (({1'b0, layer_q} + 4'd1) >= NUM_L4);
        // A stalled abort is remembered so it still takes effect once the write lands.
        abort_now      = abort || abort_pend_q;
        next_layer_id  = {28'd0, ({1'b0, layer_q} + 4'd2)};
        next_neuron_id = {24'd0, (neuron_q + 8'd1)};
        rdata_ext      = {{PAD{1'b0}}, bus.mem_rdata};
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            state_q      <= ST_IDLE;
            layer_q      <= '0;
            neuron_q     <= '0;
            weight_q     <= '0;
            ptr_q        <= '0;
            wdata_q      <= '0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            layer_q      <= layer_d;
            neuron_q     <= neuron_d;
            weight_q     <= weight_d;
            ptr_q        <= ptr_d;
            wdata_q      <= wdata_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        layer_d      = layer_q;
        neuron_d     = neuron_q;
        weight_d     = weight_q;
        ptr_d        = ptr_q;
        wdata_d      = wdata_q;
        abort_pend_d = abort_pend_q;
        busy_c       = 1'b1;
        done_c       = 1'b0;
        mem_en_c     = 1'b0;
        cfg_valid_c  = 1'b0;
        cfg_addr_c   = REG_WEIGHT;

        unique case (state_q)
            ST_IDLE: begin
                busy_c       = 1'b0;
                abort_pend_d = 1'b0;
                if (start && !abort) begin
                    state_d  = ST_SET_LAYER;
                    layer_d  = '0;
                    neuron_d = '0;
                    weight_d = '0;
                    ptr_d    = '0;
                    wdata_d  = 32'd1;
                end
            end

            ST_SET_LAYER: begin
                cfg_valid_c = 1'b1;
                cfg_addr_c  = REG_LAYER;
                if (bus.cfg_ready) begin
                    if (abort_now) begin
                        state_d = ST_IDLE;
                    end else if (n_cur == 8'd0) begin
                        // Empty layer: only its select is written.
                        if (last_layer) begin
                            state_d = ST_FINISH;
                        end else begin
                            layer_d = layer_q + 3'd1;
                            wdata_d = next_layer_id;
                        end
                    end else begin
                        state_d = ST_SET_NEURON;
                        wdata_d = '0;
                    end
                end
            end

            ST_SET_NEURON: begin
                cfg_valid_c = 1'b1;
                cfg_addr_c  = REG_NEURON;
                if (bus.cfg_ready) begin
                    state_d = abort_now ? ST_IDLE : ST_FETCH;
                end
            end

            ST_FETCH: begin
                mem_en_c = 1'b1;
                state_d  = abort ? ST_IDLE : ST_LOAD;
            end

            ST_LOAD: begin
                wdata_d = rdata_ext;
                state_d = abort ? ST_IDLE : ST_PUSH;
            end

            ST_PUSH: begin
                cfg_valid_c = 1'b1;
                cfg_addr_c  = is_bias ? REG_BIAS : REG_WEIGHT;
                if (bus.cfg_ready) begin
                    ptr_d = ptr_q + 1'b1;
                    if (abort_now) begin
                        state_d = ST_IDLE;
                    end else if (!is_bias) begin
                        weight_d = weight_q + 16'd1;
                        state_d  = ST_FETCH;
                    end else begin
                        weight_d = '0;
                        if (!last_neuron) begin
                            neuron_d = neuron_q + 8'd1;
                            wdata_d  = next_neuron_id;
                            state_d  = ST_SET_NEURON;
                        end else begin
                            neuron_d = '0;
                            if (!last_layer) begin
                                layer_d = layer_q + 3'd1;
                                wdata_d = next_layer_id;
                                state_d = ST_SET_LAYER;
                            end else begin
                                state_d = ST_FINISH;
                            end
                        end
                    end
                end
            end

            ST_FINISH: begin
                busy_c  = 1'b0;
                done_c  = !abort;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (cfg_valid_c && !bus.cfg_ready && abort) begin
            abort_pend_d = 1'b1;
        end
    end

    assign busy          = busy_c;
    assign done          = done_c;
    assign bus.mem_en    = mem_en_c;
    assign bus.mem_addr  = ptr_q;
    assign bus.cfg_valid = cfg_valid_c;
    assign bus.cfg_addr  = cfg_addr_c;
    assign bus.cfg_wdata = wdata_q;

endmodule

// File: tb/tb_cfg_load_seq.sv
// tb/tb_cfg_load_seq.sv - scoreboard bench for the configuration load sequencer
module tb_cfg_load_seq;
    import cfg_load_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic s_resetn, s_start, s_abort, s_busy, s_done, s_rnd;
    logic d_resetn, d_start, d_abort, d_busy, d_done;

    cfg_load_seq_if #(.MEM_W(17), .MEM_AW(15)) sbus ();
    cfg_load_seq_if #(.MEM_W(17), .MEM_AW(15)) dbus ();

    cfg_load_seq #(
        .NUM_LAYERS(2),
        .NEURONS_L (64'h0000_0000_0000_0102),
        .WEIGHTS_L (128'h0000_0000_0000_0000_0000_0000_0002_0003),
        .MEM_W     (17),
        .MEM_AW    (15)
    ) dut_s (
        .s_axi_aclk   (clk),
        .s_axi_aresetn(s_resetn),
        .start        (s_start),
        .abort        (s_abort),
        .busy         (s_busy),
        .done         (s_done),
        .bus          (sbus.master)
    );

    cfg_load_seq dut_d (
        .s_axi_aclk   (clk),
        .s_axi_aresetn(d_resetn),
        .start        (d_start),
        .abort        (d_abort),
        .busy         (d_busy),
        .done         (d_done),
        .bus          (dbus.master)
    );

    function automatic logic [16:0] img(input logic [14:0] a);
        return {2'b10, a ^ 15'h2AAA};
    endfunction

    always @(posedge clk) if (sbus.mem_en) sbus.mem_rdata <= {2'b00, sbus.mem_addr};
    always @(posedge clk) if (dbus.mem_en) dbus.mem_rdata <= img(dbus.mem_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hand-computed write sequence for layers {2 neurons x 3 weights, 1 neuron x 2 weights}.
    int s_exp_a [16] = '{12, 16, 0, 0, 0, 4, 16, 0, 0, 0, 4, 12, 16, 0, 0, 4};
    int s_exp_d [16] = '{ 1,  0, 0, 1, 2, 3,  1, 4, 5, 6, 7,  2,  0, 8, 9, 10};

    logic [36:0] sq[$];
    logic [36:0] dq[$];
    int s_hs = 0, s_done_cnt = 0, s_busy_cyc = 0;
    int d_hs = 0, d_done_cnt = 0, d_lsel = 0, d_nsel = 0;
    logic [36:0] d_last = '0;

    task automatic push_small();
        for (int i = 0; i < 16; i++) sq.push_back({5'(s_exp_a[i]), 32'(s_exp_d[i])});
    endtask

    task automatic pulse_s_start();
        s_start = 1'b1;
        tick(1);
        s_start = 1'b0;
    endtask

    task automatic s_wait_done(input string name, input int budget);
        int  base;
        bit  seen;
        base = s_done_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick(1);
            if (s_done_cnt != base) seen = 1'b1;
        end
        chk(name, 64'(seen), 64'd1);
    endtask

    task automatic chk_s_zero(input string tag);
        chk({tag, "_busy"},  64'(s_busy), 64'd0);
        chk({tag, "_done"},  64'(s_done), 64'd0);
        chk({tag, "_mem_en"}, 64'(sbus.mem_en), 64'd0);
        chk({tag, "_mem_addr"}, 64'(sbus.mem_addr), 64'd0);
        chk({tag, "_valid"}, 64'(sbus.cfg_valid), 64'd0);
        chk({tag, "_addr"},  64'(sbus.cfg_addr), 64'd0);
        chk({tag, "_wdata"}, 64'(sbus.cfg_wdata), 64'd0);
    endtask

    // Small-instance monitor: scoreboard pop on handshake plus hold-during-stall check.
    bit          s_stall_pend = 1'b0;
    logic [36:0] s_held = '0;
    initial forever begin
        logic [36:0] e;
        @(negedge clk);
        if (s_resetn) begin
            if (s_stall_pend) begin
                chk("s_stall_valid", 64'(sbus.cfg_valid), 64'd1);
                chk("s_stall_addr",  64'(sbus.cfg_addr),  64'(s_held[36:32]));
                chk("s_stall_wdata", 64'(sbus.cfg_wdata), 64'(s_held[31:0]));
            end
            if (sbus.cfg_valid && sbus.cfg_ready) begin
                s_hs++;
                if (sq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL s_unexpected_write actual=(%0d,%0d) expected=none",
                             sbus.cfg_addr, sbus.cfg_wdata);
                end else begin
                    e = sq.pop_front();
                    chk("s_addr",  64'(sbus.cfg_addr),  64'(e[36:32]));
                    chk("s_wdata", 64'(sbus.cfg_wdata), 64'(e[31:0]));
                end
            end
            s_stall_pend = sbus.cfg_valid && !sbus.cfg_ready;
            s_held       = {sbus.cfg_addr, sbus.cfg_wdata};
            if (s_done) s_done_cnt++;
            if (s_busy) s_busy_cyc++;
        end else begin
            s_stall_pend = 1'b0;
        end
    end

    initial forever begin
        logic [36:0] e;
        @(negedge clk);
        if (d_resetn && dbus.cfg_valid && dbus.cfg_ready) begin
            d_hs++;
            if (dbus.cfg_addr == REG_LAYER)  d_lsel++;
            if (dbus.cfg_addr == REG_NEURON) d_nsel++;
            d_last = {dbus.cfg_addr, dbus.cfg_wdata};
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL d_unexpected_write actual=(%0d,%0d) expected=none",
                         dbus.cfg_addr, dbus.cfg_wdata);
            end else begin
                e = dq.pop_front();
                chk("d_addr",  64'(dbus.cfg_addr),  64'(e[36:32]));
                chk("d_wdata", 64'(dbus.cfg_wdata), 64'(e[31:0]));
            end
        end
        if (d_resetn && d_done) d_done_cnt++;
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (s_rnd) sbus.cfg_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        s_resetn = 1'b0; s_start = 1'b0; s_abort = 1'b0; s_rnd = 1'b0;
        sbus.cfg_ready = 1'b1;
        d_resetn = 1'b0; d_start = 1'b0; d_abort = 1'b0;
        dbus.cfg_ready = 1'b1;

        fork
            begin : small_tests
                int hs0, b0, d0;
                bit hit;
                tick(3);
                chk_s_zero("rst");
                s_resetn = 1'b1;
                tick(2);

                // Full sequence, always ready
                hs0 = s_hs; b0 = s_busy_cyc; d0 = s_done_cnt;
                push_small();
                pulse_s_start();
                s_wait_done("t1_done_seen", 300);
                tick(3);
                chk("t1_handshakes", 64'(s_hs - hs0), 64'd16);
                chk("t1_busy_cycles", 64'(s_busy_cyc - b0), 64'd38);
                chk("t1_done_count", 64'(s_done_cnt - d0), 64'd1);
                chk("t1_queue_left", 64'(sq.size()), 64'd0);
                chk("t1_busy_after", 64'(s_busy), 64'd0);

                // Random backpressure
                hs0 = s_hs; d0 = s_done_cnt;
                push_small();
                s_rnd = 1'b1;
                pulse_s_start();
                s_wait_done("t2_done_seen", 2000);
                s_rnd = 1'b0;
                sbus.cfg_ready = 1'b1;
                tick(3);
                chk("t2_handshakes", 64'(s_hs - hs0), 64'd16);
                chk("t2_done_count", 64'(s_done_cnt - d0), 64'd1);
                chk("t2_queue_left", 64'(sq.size()), 64'd0);

                // Abort registered during stalled 2nd weight push of layer 1
                hs0 = s_hs; d0 = s_done_cnt;
                for (int i = 0; i < 4; i++) sq.push_back({5'(s_exp_a[i]), 32'(s_exp_d[i])});
                pulse_s_start();
                hit = 1'b0;
                for (int i = 0; i < 100 && !hit; i++) begin
                    if (sbus.cfg_valid && sbus.cfg_addr == 5'd0 && sbus.cfg_wdata == 32'd1) hit = 1'b1;
                    else tick(1);
                end
                chk("t3_reached_push", 64'(hit), 64'd1);
                sbus.cfg_ready = 1'b0;
                s_abort = 1'b1;
                tick(1);
                s_abort = 1'b0;
                tick(2);
                sbus.cfg_ready = 1'b1;
                tick(6);
                chk("t3_handshakes", 64'(s_hs - hs0), 64'd4);
                chk("t3_busy", 64'(s_busy), 64'd0);
                chk("t3_no_done", 64'(s_done_cnt - d0), 64'd0);
                chk("t3_queue_left", 64'(sq.size()), 64'd0);

                hs0 = s_hs; d0 = s_done_cnt;
                push_small();
                pulse_s_start();
                s_wait_done("t3r_done_seen", 300);
                tick(3);
                chk("t3r_handshakes", 64'(s_hs - hs0), 64'd16);
                chk("t3r_queue_left", 64'(sq.size()), 64'd0);

                // Reset in the middle of layer 2
                hs0 = s_hs;
                push_small();
                pulse_s_start();
                hit = 1'b0;
                for (int i = 0; i < 200 && !hit; i++) begin
                    tick(1);
                    if (s_hs - hs0 >= 13) hit = 1'b1;
                end
                chk("t4_reached_layer2", 64'(hit), 64'd1);
                s_resetn = 1'b0;
                sq.delete();
                tick(1);
                chk_s_zero("t4_rst");
                s_resetn = 1'b1;
                tick(3);
                chk("t4_idle_after", 64'(s_busy), 64'd0);
                hs0 = s_hs; d0 = s_done_cnt;
                push_small();
                pulse_s_start();
                s_wait_done("t4r_done_seen", 300);
                tick(3);
                chk("t4r_handshakes", 64'(s_hs - hs0), 64'd16);
                chk("t4r_done_count", 64'(s_done_cnt - d0), 64'd1);
                chk("t4r_queue_left", 64'(sq.size()), 64'd0);

                // start while busy is ignored
                hs0 = s_hs; d0 = s_done_cnt;
                push_small();
                pulse_s_start();
                tick(5);
                pulse_s_start();
                tick(15);
                pulse_s_start();
                s_wait_done("t5_done_seen", 300);
                tick(10);
                chk("t5_handshakes", 64'(s_hs - hs0), 64'd16);
                chk("t5_done_count", 64'(s_done_cnt - d0), 64'd1);
                chk("t5_busy_after", 64'(s_busy), 64'd0);
                chk("t5_queue_left", 64'(sq.size()), 64'd0);

                // start and abort together in IDLE
                hs0 = s_hs;
                s_start = 1'b1;
                s_abort = 1'b1;
                tick(1);
                s_start = 1'b0;
                s_abort = 1'b0;
                tick(4);
                chk("t6_busy", 64'(s_busy), 64'd0);
                chk("t6_handshakes", 64'(s_hs - hs0), 64'd0);
            end

            begin : default_test
                int nl [4] = '{30, 30, 10, 10};
                int wl [4] = '{784, 30, 30, 10};
                int p;
                int d0;
                bit seen;
                tick(3);
                d_resetn = 1'b1;
                tick(2);
                p = 0;
                for (int k = 0; k < 4; k++) begin
                    dq.push_back({5'd12, 32'(k + 1)});
                    for (int j = 0; j < nl[k]; j++) begin
                        dq.push_back({5'd16, 32'(j)});
                        for (int w = 0; w <= wl[k]; w++) begin
                            dq.push_back({(w == wl[k]) ? 5'd4 : 5'd0, 15'd0, img(15'(p))});
                            p++;
                        end
                    end
                end
                d0 = d_done_cnt;
                d_start = 1'b1;
                tick(1);
                d_start = 1'b0;
                seen = 1'b0;
                for (int i = 0; i < 80000 && !seen; i++) begin
                    tick(1);
                    if (d_done_cnt != d0) seen = 1'b1;
                end
                chk("d_done_seen", 64'(seen), 64'd1);
                tick(3);
                chk("d_layer_selects", 64'(d_lsel), 64'd4);
                chk("d_neuron_selects", 64'(d_nsel), 64'd80);
                chk("d_last_addr", 64'(d_last[36:32]), 64'd4);
                chk("d_last_wdata", 64'(d_last[31:0]), 64'({2'b10, 15'd24899 ^ 15'h2AAA}));
                chk("d_done_count", 64'(d_done_cnt - d0), 64'd1);
                chk("d_queue_left", 64'(dq.size()), 64'd0);
                chk("d_busy_after", 64'(d_busy), 64'd0);
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfg_load_seq.md
Name: cfg_load_seq

Overview:
- Hardware replacement for the host-driven weight/bias configuration sequence of the zyNet MLP.
- On `start`, walks a packed parameter memory (BRAM/ROM image) layer by layer and neuron by neuron.
- Emits the same register-write transactions the AXI-Lite slave accepts: layer select, neuron select, weight word, bias word.
- Sits between the parameter BRAM and the AXI-Lite register-write mux inside the top level.

Parameters:
- NUM_LAYERS, 4, number of layers configured (max 8).
- NEURONS_L, {10,10,30,30} packed 8b per layer (layer 1 in the LSB byte), neurons per layer.
- WEIGHTS_L, {10,30,30,784} packed 16b per layer (layer 1 in the LSB half-word), weights per neuron.
- MEM_W, 17, parameter-memory word width (dataWidth+1).
- MEM_AW, 15, parameter-memory address width.

Ports:
- s_axi_aclk, in, 1: clock.
- s_axi_aresetn, in, 1: synchronous active-low reset.
- start, in, 1: single-cycle request to begin loading; ignored while busy.
- abort, in, 1: stop loading.
- busy, out, 1: sequence in progress.
- done, out, 1: one-cycle pulse on normal completion.
- mem_en, out, 1: parameter-memory read enable.
- mem_addr, out, MEM_AW: word address.
- mem_rdata, in, MEM_W: read data, valid one cycle after mem_en.
- cfg_valid, out, 1: register-write request.
- cfg_ready, in, 1: write accepted.
- cfg_addr, out, 5: register offset (0 weight, 4 bias, 12 layer, 16 neuron).
- cfg_wdata, out, 32: write data.

Behaviour:
- Reset values: busy=0, done=0, mem_en=0, mem_addr=0, cfg_valid=0, cfg_addr=0, cfg_wdata=0.
- Memory layout: for each layer k=1..NUM_LAYERS, for each neuron j=0..NEURONS_L[k]-1: WEIGHTS_L[k] weight words followed by 1 bias word. Memory is contiguous from address 0.
- States:
  - IDLE
  - SET_LAYER
  - SET_NEURON
  - FETCH
  - LOAD
  - PUSH
  - FINISH
- Transitions:
  - IDLE: on start, go to SET_LAYER; clear the layer, neuron, weight and address counters; busy=1.
  - SET_LAYER: cfg_valid=1, cfg_addr=12, cfg_wdata=k (1-based). On handshake, go to SET_NEURON.
  - SET_NEURON: cfg_addr=16, cfg_wdata=j (0-based). On handshake, go to FETCH.
  - FETCH: mem_en=1, mem_addr=current pointer. Go to LOAD.
  - LOAD: latch mem_rdata zero-extended to 32b into cfg_wdata. Go to PUSH.
  - PUSH: cfg_valid=1. cfg_addr=0 while the weight counter < WEIGHTS_L[k]; otherwise cfg_addr=4 (bias). On handshake, increment the pointer, then:
    - next weight → FETCH;
    - after bias, next neuron → SET_NEURON;
    - after the last neuron, next layer → SET_LAYER;
    - after the last layer → FINISH.
  - FINISH: done=1 for one cycle, busy=0, go to IDLE.
- Handshake: a transfer occurs when cfg_valid && cfg_ready are both high at a rising edge. While cfg_valid=1, cfg_addr and cfg_wdata hold stable until the handshake. cfg_valid never deasserts without a handshake.
- Cost per transaction with cfg_ready=1: select writes take 1 cycle; data words take 3 cycles (FETCH, LOAD, PUSH).
- abort:
  - Sampled in any non-IDLE state with cfg_valid=0, or in the same cycle as a handshake.
  - When honoured: go to IDLE next cycle, busy=0, done not pulsed.
  - If abort arrives while cfg_valid=1 without ready, it is registered and honoured at the handshake.
- start while busy: ignored.
- start and abort together in IDLE: abort wins, no load begins.
- Reset mid-operation: all counters and outputs return to reset values next edge. No partial transaction is completed.
- Counter widths: neuron 8b, weight 16b, layer 3b.
- Zero entries: a layer with NEURONS_L=0 emits only SET_LAYER. WEIGHTS_L=0 emits only the bias per neuron.

Decomposition:
- Package cfg_load_pkg holds:
  - register offset constants (REG_WEIGHT=0, REG_BIAS=4, REG_OUT=8, REG_LAYER=12, REG_NEURON=16, REG_STATUS=24, REG_SRST=28);
  - the state enum;
  - helper functions to extract NEURONS_L and WEIGHTS_L fields.
- No sub-module is needed. The pointer/neuron/weight counter bank may live in cfg_load_cnt if preferred.

Test Plan:
- Small config NUM_LAYERS=2, NEURONS={1,2}, WEIGHTS={2,3}, memory = address value, cfg_ready=1; pulse start → transaction sequence:
  - (12,1)(16,0)(0,0)(0,1)(0,2)(4,3)(16,1)(0,4)(0,5)(0,6)(4,7)
  - (12,2)(16,0)(0,8)(0,9)(4,10)
  - 16 handshakes in 38 handshake-path cycles; done pulses once; busy low afterwards.
- Same config, cfg_ready toggled pseudo-randomly → identical transaction sequence; cfg_addr and cfg_wdata stable through every stall; no duplicate or lost word.
- abort asserted during the 2nd PUSH of layer 1 with ready low → that handshake completes, then IDLE; no done; a new start restarts from (12,1).
- Synchronous reset asserted mid-layer 2 → all outputs 0 next cycle. A subsequent start replays the full sequence from address 0.
- start re-pulsed while busy → ignored; the sequence is unaltered; exactly one done.
- Default parameters with a 24900-word image → last write is (4, image[24899]); 4 layer selects; 80 neuron selects; done once.
